// File: rtl/instruction_queue_if.sv
// rtl/instruction_queue_if.sv - fetch/controller handshake bundle for instruction_queue
// Fetch drives the push side (master); the queue sits on the slave modport.
interface instruction_queue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             advance;
  logic             flush;
  logic [WIDTH-1:0] ir;
  logic             ir_valid;
  logic [CW-1:0]    count;
  logic             ovf;

  modport master (
    output in_data, in_valid, advance, flush,
    input  in_ready, ir, ir_valid, count, ovf
  );

  modport slave (
    input  in_data, in_valid, advance, flush,
    output in_ready, ir, ir_valid, count, ovf
  );
endinterface

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - DEPTH-entry instruction FIFO replacing the single-word IR
// Define IQ_LAST_HOLD_EN to keep the last popped word on ir while the queue is empty.
module instruction_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  instruction_queue_if.slave q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, not_empty, push, pop;
  logic [WIDTH-1:0] empty_ir;

  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = q.in_valid & ~full & ~q.flush;
  assign pop       = q.advance & not_empty & ~q.flush;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (q.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = q.in_data;
        wptr_d        = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (q.in_valid && full) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: ir is gated by count, so stale entries never leak out.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef IQ_LAST_HOLD_EN
  logic [WIDTH-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (pop) begin
      hold_d = mem_q[rptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign empty_ir = hold_q;
`else
  assign empty_ir = '0;
`endif

  assign q.in_ready = ~full;
  assign q.ir_valid = not_empty;
  assign q.count    = count_q;
  assign q.ovf      = ovf_q;
  assign q.ir       = not_empty ? mem_q[rptr_q] : empty_ir;
endmodule
